// File: rtl/netdma_mm_arbiter_if.sv
// Bus bundle for the two-master netdma arbiter: both upstream master ports and the
// shared downstream Avalon-MM port. The master modport is the arbiter's view.
interface netdma_mm_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 29
);
  logic [2*ADDR_WIDTH-1:0]   m_address_i;
  logic [1:0]                m_read_i;
  logic [1:0]                m_write_i;
  logic [2*DATA_WIDTH-1:0]   m_writedata_i;
  logic [2*DATA_WIDTH/8-1:0] m_byteenable_i;
  logic [1:0]                m_waitrequest_o;
  logic [DATA_WIDTH-1:0]     m_readdata_o;
  logic [1:0]                m_readdatavalid_o;
  logic [ADDR_WIDTH-1:0]     s_address_o;
  logic                      s_read_o;
  logic                      s_write_o;
  logic [DATA_WIDTH-1:0]     s_writedata_o;
  logic [DATA_WIDTH/8-1:0]   s_byteenable_o;
  logic                      s_waitrequest_i;
  logic [DATA_WIDTH-1:0]     s_readdata_i;
  logic                      s_readdatavalid_i;

  modport master (
    input  m_address_i, m_read_i, m_write_i, m_writedata_i, m_byteenable_i,
    output m_waitrequest_o, m_readdata_o, m_readdatavalid_o,
    output s_address_o, s_read_o, s_write_o, s_writedata_o, s_byteenable_o,
    input  s_waitrequest_i, s_readdata_i, s_readdatavalid_i
  );

  modport slave (
    output m_address_i, m_read_i, m_write_i, m_writedata_i, m_byteenable_i,
    input  m_waitrequest_o, m_readdata_o, m_readdatavalid_o,
    input  s_address_o, s_read_o, s_write_o, s_writedata_o, s_byteenable_o,
    output s_waitrequest_i, s_readdata_i, s_readdatavalid_i
  );
endinterface

// File: rtl/netdma_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port between two netdma masters; read
// responses are steered back to their issuer through an in-order ID FIFO.
module netdma_mm_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 29,
  parameter int MAX_PENDING = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  netdma_mm_arbiter_if.master bus,
  output logic                err_o
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state_q, state_d;
  logic            rr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            err_q;
  logic            id_mem [MAX_PENDING];

  logic [1:0] req;
  logic       granted, gnt_id, other;
  logic       g_read, g_write, full, empty;
  logic       fwd_rd, fwd_wr, accept, push, pop, head_id;

  assign req     = bus.m_read_i | bus.m_write_i;
  assign granted = (state_q != IDLE);
  assign gnt_id  = (state_q == GNT1);
  assign other   = ~gnt_id;
  // Read wins over an (illegal) simultaneous write from the same master.
  assign g_read  = granted & bus.m_read_i[gnt_id];
  assign g_write = granted & bus.m_write_i[gnt_id] & ~g_read;
  assign full    = (cnt_q == CW'(MAX_PENDING));
  assign empty   = (cnt_q == '0);
  assign fwd_rd  = g_read & ~full;
  assign fwd_wr  = g_write;
  assign accept  = (fwd_rd | fwd_wr) & ~bus.s_waitrequest_i;
  assign push    = accept & fwd_rd;
  // Pop is qualified by the pre-push count: a response never matches this cycle's read.
  assign pop     = bus.s_readdatavalid_i & ~empty;
  assign head_id = id_mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req == 2'b11)  state_d = rr_q ? GNT1 : GNT0;
        else if (req[0])   state_d = GNT0;
        else if (req[1])   state_d = GNT1;
      end
      GNT0, GNT1: begin
        // Never re-grant the same master back to back; a dropped request releases the grant.
        if (accept)             state_d = req[other] ? (other ? GNT1 : GNT0) : IDLE;
        else if (!req[gnt_id])  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_read_o          = fwd_rd;
    bus.s_write_o         = fwd_wr;
    bus.s_address_o       = gnt_id ? bus.m_address_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : bus.m_address_i[ADDR_WIDTH-1:0];
    bus.s_writedata_o     = gnt_id ? bus.m_writedata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : bus.m_writedata_i[DATA_WIDTH-1:0];
    bus.s_byteenable_o    = gnt_id ? bus.m_byteenable_i[2*BW-1:BW]
                                   : bus.m_byteenable_i[BW-1:0];
    bus.m_waitrequest_o   = 2'b11;
    if (fwd_rd | fwd_wr) bus.m_waitrequest_o[gnt_id] = bus.s_waitrequest_i;
    bus.m_readdata_o      = bus.s_readdata_i;
    bus.m_readdatavalid_o = 2'b00;
    if (pop) bus.m_readdatavalid_o = head_id ? 2'b10 : 2'b01;
    err_o                 = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) rr_q <= other;
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (bus.s_readdatavalid_i && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_q] <= gnt_id;
  end
endmodule

// File: tb/tb_netdma_mm_arbiter.sv
// Bench for netdma_mm_arbiter: scripted vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_netdma_mm_arbiter;
  localparam int DW = 64;
  localparam int AW = 29;
  localparam int MP = 8;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic err_o;

  always #5 clk_i = ~clk_i;

  netdma_mm_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  netdma_mm_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PENDING(MP)) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus),
    .err_o  (err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] rd, wr;
    logic       sw, sv;
    logic       e_rd, e_wr;
    logic [1:0] e_wait, e_rdv;
    logic       e_err;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_address_i       = '0;
    bus.m_read_i          = '0;
    bus.m_write_i         = '0;
    bus.m_writedata_i     = '0;
    bus.m_byteenable_i    = '1;
    bus.s_waitrequest_i   = 1'b0;
    bus.s_readdata_i      = '0;
    bus.s_readdatavalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    #10;
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic issue_read(input int k, input string name);
    bit done = 1'b0;
    bus.m_read_i = (k == 1) ? 2'b10 : 2'b01;
    for (int c = 0; c < 10 && !done; c++) begin
      #2;
      done = !bus.m_waitrequest_o[k];
      tick();
    end
    bus.m_read_i = '0;
    chk(name, done, 1'b1);
  endtask

  // Reference-model state for the randomized run
  int         gnt;
  int         rr;
  int         q[$];
  bit         merr;
  bit   [1:0] act, isrd;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mdata [2];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[1]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[2]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[6]  = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[11] = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1};
    tbl[12] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1};
    tbl[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[14] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1};
    tbl[15] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1};

    // Reset state
    rst_n_i = 1'b0;
    idle_inputs();
    #3;
    chk("reset_s_read",  bus.s_read_o, 1'b0);
    chk("reset_s_write", bus.s_write_o, 1'b0);
    chk("reset_m_wait",  bus.m_waitrequest_o, 2'b11);
    chk("reset_m_rdv",   bus.m_readdatavalid_o, 2'b00);
    chk("reset_err",     err_o, 1'b0);
    #8;
    rst_n_i = 1'b1;
    tick();

    // Scripted vector table
    for (int i = 0; i < 17; i++) begin
      bus.m_read_i          = tbl[i].rd;
      bus.m_write_i         = tbl[i].wr;
      bus.s_waitrequest_i   = tbl[i].sw;
      bus.s_readdatavalid_i = tbl[i].sv;
      #2;
      chk($sformatf("tbl%0d_s_read", i),  bus.s_read_o, tbl[i].e_rd);
      chk($sformatf("tbl%0d_s_write", i), bus.s_write_o, tbl[i].e_wr);
      chk($sformatf("tbl%0d_m_wait", i),  bus.m_waitrequest_o, tbl[i].e_wait);
      chk($sformatf("tbl%0d_m_rdv", i),   bus.m_readdatavalid_o, tbl[i].e_rdv);
      chk($sformatf("tbl%0d_err", i),     err_o, tbl[i].e_err);
      tick();
    end

    // Single master-0 write
    do_reset();
    bus.m_address_i   = {AW'(0), AW'('h100)};
    bus.m_writedata_i = {64'h0, 64'hDEADBEEF_01234567};
    bus.m_write_i     = 2'b01;
    #2;
    chk("single_idle_wait", bus.m_waitrequest_o, 2'b11);
    tick();
    #2;
    chk("single_fwd", {bus.s_write_o, bus.s_address_o, bus.s_writedata_o, bus.m_waitrequest_o},
        {1'b1, AW'('h100), 64'hDEADBEEF_01234567, 2'b10});
    tick();
    bus.m_write_i = 2'b00;
    #2;
    chk("single_after", {bus.s_write_o, bus.m_waitrequest_o}, {1'b0, 2'b11});
    tick();

    // Both masters writing continuously: alternating full-rate grants
    begin
      int acc = 0, n0 = 0, n1 = 0, alt_bad = 0, id;
      do_reset();
      bus.m_address_i = {AW'('h222), AW'('h111)};
      bus.m_write_i   = 2'b11;
      for (int c = 0; c < 101; c++) begin
        #2;
        if (bus.s_write_o && !bus.s_waitrequest_i) begin
          id = (bus.s_address_o == AW'('h222)) ? 1 : 0;
          if (id != acc % 2) alt_bad++;
          if (id == 1) n1++; else n0++;
          acc++;
        end
        tick();
      end
      bus.m_write_i = 2'b00;
      chk("rr_total", acc, 100);
      chk("rr_m0", n0, 50);
      chk("rr_m1", n1, 50);
      chk("rr_alternation_bad", alt_bad, 0);
    end

    // Read blocking at MAX_PENDING
    begin
      int acc = 0;
      do_reset();
      bus.m_read_i = 2'b01;
      for (int c = 0; c < 40 && acc < MP; c++) begin
        #2;
        if (bus.s_read_o) acc++;
        tick();
      end
      chk("stall_reads_issued", acc, MP);
      for (int c = 0; c < 4; c++) begin
        #2;
        chk("stall_blocked", {bus.s_read_o, bus.m_waitrequest_o}, {1'b0, 2'b11});
        tick();
      end
      bus.s_readdatavalid_i = 1'b1;
      #2;
      chk("stall_rdv_cycle", {bus.s_read_o, bus.m_readdatavalid_o}, {1'b0, 2'b01});
      tick();
      bus.s_readdatavalid_i = 1'b0;
      #2;
      chk("stall_release", {bus.s_read_o, bus.m_waitrequest_o}, {1'b1, 2'b10});
      tick();
      bus.m_read_i = 2'b00;
    end

    // Interleaved reads M0,M1,M0 returned in order
    begin
      logic [DW-1:0] rdat [3];
      logic [1:0]    rexp [3];
      rdat[0] = 64'hA; rdat[1] = 64'hB; rdat[2] = 64'hC;
      rexp[0] = 2'b01; rexp[1] = 2'b10; rexp[2] = 2'b01;
      do_reset();
      issue_read(0, "ilv_issue0");
      issue_read(1, "ilv_issue1");
      issue_read(0, "ilv_issue2");
      for (int c = 0; c < 5; c++) tick();
      for (int i = 0; i < 3; i++) begin
        bus.s_readdatavalid_i = 1'b1;
        bus.s_readdata_i      = rdat[i];
        #2;
        chk($sformatf("ilv_rdv%0d", i), bus.m_readdatavalid_o, rexp[i]);
        chk($sformatf("ilv_data%0d", i), bus.m_readdata_o, rdat[i]);
        tick();
      end
      bus.s_readdatavalid_i = 1'b0;
      #2;
      chk("ilv_done", {bus.m_readdatavalid_o, err_o}, {2'b00, 1'b0});
      tick();
    end

    // Slave waitrequest held on a granted write
    do_reset();
    bus.m_address_i     = {AW'('h0BEEF), AW'('h0CAFE)};
    bus.m_writedata_i   = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    bus.m_write_i       = 2'b11;
    bus.s_waitrequest_i = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      #2;
      chk($sformatf("hold_c%0d", c),
          {bus.s_write_o, bus.s_address_o, bus.s_writedata_o, bus.m_waitrequest_o},
          {1'b1, AW'('h0CAFE), 64'h5555_6666_7777_8888, 2'b11});
      tick();
    end
    bus.s_waitrequest_i = 1'b0;
    #2;
    chk("hold_accept", bus.m_waitrequest_o, 2'b10);
    tick();
    #2;
    chk("hold_next_m1", {bus.s_write_o, bus.s_address_o, bus.m_waitrequest_o},
        {1'b1, AW'('h0BEEF), 2'b01});
    tick();
    bus.m_write_i = 2'b00;

    // Unexpected readdatavalid and reset clearing
    do_reset();
    bus.s_readdatavalid_i = 1'b1;
    #2;
    chk("unexp_no_rdv", bus.m_readdatavalid_o, 2'b00);
    tick();
    bus.s_readdatavalid_i = 1'b0;
    #2;
    chk("unexp_err_set", err_o, 1'b1);
    tick();
    #2;
    chk("unexp_err_sticky", err_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk("unexp_err_cleared", err_o, 1'b0);
    #6;
    rst_n_i = 1'b1;
    tick();
    issue_read(0, "rst_issue0");
    issue_read(1, "rst_issue1");
    issue_read(0, "rst_issue2");
    do_reset();
    bus.s_readdatavalid_i = 1'b1;
    #2;
    chk("late_rsp_no_rdv", {bus.m_readdatavalid_o, err_o}, {2'b00, 1'b0});
    tick();
    bus.s_readdatavalid_i = 1'b0;
    #2;
    chk("late_rsp_err", err_o, 1'b1);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    gnt = -1; rr = 0; merr = 1'b0; q.delete(); act = '0; isrd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit [1:0] req, ewait, erdv;
      bit erd, ewr, acc, sw, sv;
      for (int m = 0; m < 2; m++) begin
        if (act[m] && $urandom_range(0, 39) == 0) act[m] = 1'b0;
        else if (!act[m] && $urandom_range(0, 2) == 0) begin
          act[m]   = 1'b1;
          isrd[m]  = $urandom_range(0, 1) == 1;
          maddr[m] = AW'($urandom);
          mdata[m] = {$urandom, $urandom};
        end
        bus.m_read_i[m]                = act[m] & isrd[m];
        bus.m_write_i[m]               = act[m] & ~isrd[m];
        bus.m_address_i[m*AW +: AW]    = maddr[m];
        bus.m_writedata_i[m*DW +: DW]  = mdata[m];
      end
      sw = ($urandom_range(0, 3) == 0);
      sv = (q.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      bus.s_waitrequest_i   = sw;
      bus.s_readdatavalid_i = sv;
      bus.s_readdata_i      = {$urandom, $urandom};
      req = act;

      erd = 1'b0; ewr = 1'b0; ewait = 2'b11;
      if (gnt >= 0) begin
        if (act[gnt] && isrd[gnt]) erd = (q.size() < MP);
        else if (act[gnt])         ewr = 1'b1;
        if (erd || ewr) ewait[gnt] = sw;
      end
      acc  = (erd || ewr) && !sw;
      erdv = (sv && q.size() > 0) ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;

      #2;
      chk("rnd_s_read",  bus.s_read_o, erd);
      chk("rnd_s_write", bus.s_write_o, ewr);
      chk("rnd_m_wait",  bus.m_waitrequest_o, ewait);
      chk("rnd_m_rdv",   bus.m_readdatavalid_o, erdv);
      chk("rnd_err",     err_o, merr);
      if (erdv != 2'b00) chk("rnd_rdata", bus.m_readdata_o, bus.s_readdata_i);
      if (erd || ewr)    chk("rnd_addr", bus.s_address_o, maddr[gnt]);
      if (ewr)           chk("rnd_wdata", bus.s_writedata_o, mdata[gnt]);

      if (sv) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1'b1;
      end
      if (acc && erd) q.push_back(gnt);
      if (gnt < 0) begin
        if (req == 2'b11)  gnt = rr;
        else if (req[0])   gnt = 0;
        else if (req[1])   gnt = 1;
      end else if (acc) begin
        act[gnt] = 1'b0;
        rr  = 1 - gnt;
        gnt = req[1-gnt] ? 1 - gnt : -1;
      end else if (!req[gnt]) begin
        gnt = -1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
